// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared types for the two-port memory arbiter:
//   arb_state_t : transaction FSM states (IDLE -> ISSUE -> [WAIT] -> RESP).
//   grant_t     : one-hot owner encoding, bit 0 = m0 (I-cache refill),
//                 bit 1 = m1 (D-cache / LSU).
//   GRANT_*     : the three legal grant_t values.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef logic [1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_M0   = 2'b01;
    localparam grant_t GRANT_M1   = 2'b10;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//
// Purely combinational two-input round-robin choice.
//   req0_i       : m0 request
//   req1_i       : m1 request
//   last_grant_i : one-hot owner of the previous transaction
//   grant_o      : one-hot winner, GRANT_NONE when neither requests
//
// A lone requester always wins. On a tie the port that did NOT own the
// previous transaction wins, which gives strict alternation under load.
// -----------------------------------------------------------------------------
module rr_picker
    import mem_port_arbiter_pkg::*;
(
    input  logic   req0_i,
    input  logic   req1_i,
    input  grant_t last_grant_i,
    output grant_t grant_o
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        grant_o = GRANT_NONE;
        if (req0_i && req1_i) begin
            grant_o = (last_grant_i == GRANT_M0) ? GRANT_M1 : GRANT_M0;
        end else if (req0_i) begin
            grant_o = GRANT_M0;
        end else if (req1_i) begin
            grant_o = GRANT_M1;
        end
    end

endmodule : rr_picker

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between the I-cache refill port
// (m0) and the D-cache/LSU port (m1). One word per grant, exactly one memory
// strobe per transaction, registered read data returned with a one-cycle ack.
//
// Parameters
//   ADDR_WIDTH   : word address width
//   DATA_WIDTH   : data width, multiple of 8
//   READ_LATENCY : cycles from mem_en_o to valid mem_rdata_i, legal 1..4
//
// Ports
//   clk_i, rst_i            : core clock, synchronous active-high reset
//   mX_req_i                : request valid, held until mX_ack_o
//   mX_we_i                 : 1 = write, 0 = read
//   mX_addr_i               : word address
//   mX_wdata_i, mX_wstrb_i  : write data and byte enables
//   mX_rdata_o              : registered read data, valid with mX_ack_o
//   mX_ack_o                : one-cycle completion pulse
//   mem_en_o                : memory strobe, one cycle per transaction
//   mem_we_o                : byte write enables, zero on reads
//   mem_addr_o, mem_wdata_o : memory address / write data
//   mem_rdata_i             : memory read data
//   busy_o                  : high whenever the FSM is not IDLE
//   grant_o                 : one-hot owner of the current transaction
//
// Transaction timing, request seen in IDLE at cycle t:
//   t+1 ISSUE (mem_en_o), write ack at t+2,
//   read data captured at t+1+READ_LATENCY, read ack at t+2+READ_LATENCY.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_ack_o,

    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_ack_o,

    output logic                    mem_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    busy_o,
    output logic [1:0]              grant_o
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(READ_LATENCY + 1);

    // Counter value loaded in ISSUE so that the capture lands on the last
    // WAIT cycle; READ_LATENCY=1 captures in the first WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_t              state_q,      state_d;
    grant_t                  owner_q,      owner_d;
    grant_t                  last_grant_q, last_grant_d;
    logic                    cmd_we_q,     cmd_we_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q,   cmd_addr_d;
    logic [DATA_WIDTH-1:0]   cmd_wdata_q,  cmd_wdata_d;
    logic [STRB_W-1:0]       cmd_wstrb_q,  cmd_wstrb_d;
    logic [CNT_W-1:0]        lat_cnt_q,    lat_cnt_d;
    logic [DATA_WIDTH-1:0]   m0_rdata_q,   m0_rdata_d;
    logic [DATA_WIDTH-1:0]   m1_rdata_q,   m1_rdata_d;

    grant_t                  pick;

    // -------------------------------------------------------------------------
    // Round-robin selection, only consumed in IDLE
    // -------------------------------------------------------------------------
    rr_picker u_rr_picker (
        .req0_i       (m0_req_i),
        .req1_i       (m1_req_i),
        .last_grant_i (last_grant_q),
        .grant_o      (pick)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_wstrb_d  = cmd_wstrb_q;
        lat_cnt_d    = lat_cnt_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        unique case (state_q)
            IDLE: begin
                // The command registers are the only path from the request
                // ports to the memory, so requester inputs may change freely
                // once the transaction has left IDLE.
                if (pick != GRANT_NONE) begin
                    owner_d      = pick;
                    last_grant_d = pick;
                    state_d      = ISSUE;
                    if (pick == GRANT_M0) begin
                        cmd_we_d    = m0_we_i;
                        cmd_addr_d  = m0_addr_i;
                        cmd_wdata_d = m0_wdata_i;
                        cmd_wstrb_d = m0_wstrb_i;
                    end else begin
                        cmd_we_d    = m1_we_i;
                        cmd_addr_d  = m1_addr_i;
                        cmd_wdata_d = m1_wdata_i;
                        cmd_wstrb_d = m1_wstrb_i;
                    end
                end
            end

            ISSUE: begin
                if (cmd_we_q) begin
                    state_d = RESP;
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = CNT_LOAD;
                end
            end

            WAIT: begin
                if (lat_cnt_q == '0) begin
                    // Read data is valid this cycle; only the owner's
                    // register moves, the other port's data is held.
                    if (owner_q == GRANT_M0) begin
                        m0_rdata_d = mem_rdata_i;
                    end else begin
                        m1_rdata_d = mem_rdata_i;
                    end
                    state_d = RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Reset abandons any transaction in flight: back to IDLE with no
            // ack. last_grant starts at m1 so m0 wins the first tie. The read
            // data registers are cleared too, so a requester never sees stale
            // data from before reset.
            state_q      <= IDLE;
            owner_q      <= GRANT_NONE;
            last_grant_q <= GRANT_M1;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_wstrb_q  <= '0;
            lat_cnt_q    <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_wstrb_q  <= cmd_wstrb_d;
            lat_cnt_q    <= lat_cnt_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    assign mem_en_o    = (state_q == ISSUE);
    assign mem_we_o    = (state_q == ISSUE && cmd_we_q) ? cmd_wstrb_q : '0;
    // Address and write data come straight from the command registers; they
    // are only meaningful while mem_en_o is high.
    assign mem_addr_o  = cmd_addr_q;
    assign mem_wdata_o = cmd_wdata_q;

    assign m0_ack_o    = (state_q == RESP) && (owner_q == GRANT_M0);
    assign m1_ack_o    = (state_q == RESP) && (owner_q == GRANT_M1);
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

    assign busy_o      = (state_q != IDLE);
    assign grant_o     = (state_q == IDLE) ? GRANT_NONE : owner_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances share the requester-side stimulus:
//   dut_a : READ_LATENCY=1, attached to a small behavioural byte-write memory
//   dut_b : READ_LATENCY=3, mem_rdata driven directly by the bench so the
//           capture cycle can be pinned down exactly
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_m0_ack, a_m1_ack, a_mem_en, a_busy;
    logic [3:0]  a_mem_we;
    logic [1:0]  a_grant;

    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_m0_ack, b_m1_ack, b_mem_en, b_busy;
    logic [3:0]  b_mem_we;
    logic [1:0]  b_grant;

    logic [31:0] mem [0:255];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
        .m0_rdata_o(a_m0_rdata), .m0_ack_o(a_m0_ack),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
        .m1_rdata_o(a_m1_rdata), .m1_ack_o(a_m1_ack),
        .mem_en_o(a_mem_en), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata),
        .busy_o(a_busy), .grant_o(a_grant)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
        .m0_rdata_o(b_m0_rdata), .m0_ack_o(b_m0_ack),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
        .m1_rdata_o(b_m1_rdata), .m1_ack_o(b_m1_ack),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
        .busy_o(b_busy), .grant_o(b_grant)
    );

    // Memory model for dut_a: one-cycle read latency, byte-masked writes,
    // contents restored while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0100_0000 + i;
            mem[8'h10] <= 32'hDEAD_BEEF;
            mem[8'h20] <= 32'h1234_5678;
        end else if (a_mem_en) begin
            for (int b = 0; b < 4; b++)
                if (a_mem_we[b]) mem[a_mem_addr[7:0]][b*8 +: 8] <= a_mem_wdata[b*8 +: 8];
            a_mem_rdata <= mem[a_mem_addr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        m0_req = 1'b0;
        m1_req = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if ({a_m0_ack, a_m1_ack, a_mem_en, a_busy} !== 4'b0000 || a_grant !== 2'b00 ||
                a_mem_we !== 4'h0 || a_mem_addr !== 32'h0 || a_mem_wdata !== 32'h0 ||
                a_m0_rdata !== 32'h0 || a_m1_rdata !== 32'h0) begin
                $display("FAIL reset_outputs_a cyc%0d: ack=%b%b en=%b busy=%b grant=%b we=%h addr=%h wd=%h rd0=%h rd1=%h, want all 0",
                         c, a_m0_ack, a_m1_ack, a_mem_en, a_busy, a_grant, a_mem_we, a_mem_addr, a_mem_wdata, a_m0_rdata, a_m1_rdata);
                miscompares++;
            end
            vectors++;
            if ({b_m0_ack, b_m1_ack, b_mem_en, b_busy} !== 4'b0000 || b_grant !== 2'b00) begin
                $display("FAIL reset_outputs_b cyc%0d: ack=%b%b en=%b busy=%b grant=%b, want all 0",
                         c, b_m0_ack, b_m1_ack, b_mem_en, b_busy, b_grant);
                miscompares++;
            end
        end
        rst = 1'b0;          // IDLE with both requests pending
        tick();              // ISSUE
        vectors++;
        if (a_grant !== 2'b01 || a_mem_en !== 1'b1) begin
            $display("FAIL first_grant: grant=%b en=%b, want 01 1", a_grant, a_mem_en);
            miscompares++;
        end
        m1_req = 1'b0;
        tick(); tick();      // WAIT, RESP
        vectors++;
        if (a_m0_ack !== 1'b1 || a_m0_rdata !== 32'h0100_0000) begin
            $display("FAIL first_read: ack=%b rdata=%h, want 1 01000000", a_m0_ack, a_m0_rdata);
            miscompares++;
        end
        m0_req = 1'b0;
        tick();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_single_read();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        vectors++;
        if (a_busy !== 1'b0) begin
            $display("FAIL read_idle: busy=%b, want 0", a_busy);
            miscompares++;
        end
        tick();   // t+1
        vectors++;
        if (a_mem_en !== 1'b1 || a_mem_addr !== 32'h10 || a_mem_we !== 4'h0 || a_grant !== 2'b01) begin
            $display("FAIL read_issue: en=%b addr=%h we=%h grant=%b, want 1 10 0 01",
                     a_mem_en, a_mem_addr, a_mem_we, a_grant);
            miscompares++;
        end
        tick();   // t+2
        vectors++;
        if (a_mem_en !== 1'b0 || a_m0_ack !== 1'b0 || a_busy !== 1'b1) begin
            $display("FAIL read_wait: en=%b ack=%b busy=%b, want 0 0 1", a_mem_en, a_m0_ack, a_busy);
            miscompares++;
        end
        tick();   // t+3
        vectors++;
        if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0 || a_m0_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL read_ack: ack=%b%b rdata=%h, want 1 0 deadbeef", a_m0_ack, a_m1_ack, a_m0_rdata);
            miscompares++;
        end
        vectors++;
        if (a_m1_rdata !== 32'h0) begin
            $display("FAIL read_other_port: m1_rdata=%h, want 0", a_m1_rdata);
            miscompares++;
        end
        m0_req = 1'b0;
        tick();   // t+4
        vectors++;
        if (a_m0_ack !== 1'b0 || a_busy !== 1'b0) begin
            $display("FAIL read_ack_width: ack=%b busy=%b, want 0 0", a_m0_ack, a_busy);
            miscompares++;
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_byte_write();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0011;
        tick();   // t+1
        vectors++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 4'b0011 || a_mem_addr !== 32'h20 ||
            a_mem_wdata !== 32'hA5A5_A5A5 || a_grant !== 2'b10) begin
            $display("FAIL write_issue: en=%b we=%b addr=%h wd=%h grant=%b, want 1 0011 20 a5a5a5a5 10",
                     a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_grant);
            miscompares++;
        end
        tick();   // t+2
        vectors++;
        if (a_m1_ack !== 1'b1 || a_m0_ack !== 1'b0 || a_mem_en !== 1'b0) begin
            $display("FAIL write_ack: ack=%b%b en=%b, want 0 1 0", a_m0_ack, a_m1_ack, a_mem_en);
            miscompares++;
        end
        vectors++;
        if (mem[8'h20] !== 32'h1234_A5A5) begin
            $display("FAIL write_bytes: mem[20]=%h, want 1234a5a5", mem[8'h20]);
            miscompares++;
        end
        vectors++;
        if (a_m1_rdata !== 32'h0 || a_m0_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL write_rdata_hold: rd0=%h rd1=%h, want deadbeef 0", a_m0_rdata, a_m1_rdata);
            miscompares++;
        end
        m1_req = 1'b0;
        tick();   // t+3
        vectors++;
        if (a_m1_ack !== 1'b0) begin
            $display("FAIL write_ack_width: ack=%b, want 0", a_m1_ack);
            miscompares++;
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [1:0] seq [8];
        int         issue_cyc [8];
        int         n = 0, acks0 = 0, acks1 = 0, doubles = 0;
        logic       prev0 = 1'b0, prev1 = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hA0; m0_wstrb = 4'hF;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h41; m1_wdata = 32'hB1; m1_wstrb = 4'hF;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            tick();
            if (a_mem_en && n < 8) begin
                seq[n] = a_grant;
                issue_cyc[n] = cyc;
                n++;
            end
            if ((a_m0_ack && prev0) || (a_m1_ack && prev1) || (a_m0_ack && a_m1_ack)) doubles++;
            prev0 = a_m0_ack;
            prev1 = a_m1_ack;
            if (a_m0_ack) acks0++;
            if (a_m1_ack) acks1++;
            if (acks0 + acks1 == 6) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
        vectors++;
        if (n !== 6) begin
            $display("FAIL rr_count: grants=%0d, want 6", n);
            miscompares++;
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (i >= n || seq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10) || issue_cyc[i] !== 1 + 3 * i) begin
                $display("FAIL rr_grant%0d: grant=%b at cyc %0d, want %b at cyc %0d",
                         i, seq[i], issue_cyc[i], (i % 2 == 0) ? 2'b01 : 2'b10, 1 + 3 * i);
                miscompares++;
            end
        end
        vectors++;
        if (acks0 !== 3 || acks1 !== 3 || doubles !== 0) begin
            $display("FAIL rr_acks: m0=%0d m1=%0d overlong=%0d, want 3 3 0", acks0, acks1, doubles);
            miscompares++;
        end
        vectors++;
        if (mem[8'h40] !== 32'hA0 || mem[8'h41] !== 32'hB1) begin
            $display("FAIL rr_data: mem40=%h mem41=%h, want a0 b1", mem[8'h40], mem[8'h41]);
            miscompares++;
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_latency3();
        settle(8);
        vectors++;
        if (b_busy !== 1'b0) begin
            $display("FAIL lat3_idle: busy=%b, want 0", b_busy);
            miscompares++;
        end
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30;
        b_mem_rdata = 32'h3300_0000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if (b_m1_ack !== (k == 5) || b_m0_ack !== 1'b0 || b_mem_en !== (k == 1)) begin
                $display("FAIL lat3_cyc%0d: ack=%b%b en=%b, want 0 %b %b",
                         k, b_m0_ack, b_m1_ack, b_mem_en, (k == 5), (k == 1));
                miscompares++;
            end
            if (k == 5) begin
                vectors++;
                if (b_m1_rdata !== 32'h3300_0004) begin
                    $display("FAIL lat3_data: rdata=%h, want 33000004", b_m1_rdata);
                    miscompares++;
                end
                m1_req = 1'b0;
            end
            b_mem_rdata = 32'h3300_0000 + k;
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid_read();
        settle(8);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        tick();   // t+1 ISSUE
        vectors++;
        if (a_mem_en !== 1'b1 || a_grant !== 2'b01) begin
            $display("FAIL mid_issue: en=%b grant=%b, want 1 01", a_mem_en, a_grant);
            miscompares++;
        end
        tick();   // t+2 WAIT
        rst = 1'b1;
        tick();   // t+3
        vectors++;
        if (a_busy !== 1'b0 || a_grant !== 2'b00 || a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0 ||
            a_mem_en !== 1'b0 || a_mem_we !== 4'h0 || a_m0_rdata !== 32'h0) begin
            $display("FAIL mid_abandon: busy=%b grant=%b ack=%b%b en=%b we=%h rd0=%h, want 0 00 00 0 0 0",
                     a_busy, a_grant, a_m0_ack, a_m1_ack, a_mem_en, a_mem_we, a_m0_rdata);
            miscompares++;
        end
        rst = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h05;
        tick();   // t+4
        vectors++;
        if (a_grant !== 2'b01 || a_mem_en !== 1'b1 || a_m0_ack !== 1'b0) begin
            $display("FAIL mid_tie: grant=%b en=%b ack=%b, want 01 1 0", a_grant, a_mem_en, a_m0_ack);
            miscompares++;
        end
        tick(); tick();   // t+6 RESP
        vectors++;
        if (a_m0_ack !== 1'b1 || a_m0_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL mid_redo: ack=%b rdata=%h, want 1 deadbeef", a_m0_ack, a_m0_rdata);
            miscompares++;
        end
        m0_req = 1'b0;
        tick(); tick();   // t+8 ISSUE for m1
        vectors++;
        if (a_grant !== 2'b10 || a_mem_en !== 1'b1 || a_mem_addr !== 32'h05) begin
            $display("FAIL mid_next: grant=%b en=%b addr=%h, want 10 1 05", a_grant, a_mem_en, a_mem_addr);
            miscompares++;
        end
        tick(); tick();   // t+10 RESP
        vectors++;
        if (a_m1_ack !== 1'b1 || a_m1_rdata !== 32'h0100_0005) begin
            $display("FAIL mid_next_ack: ack=%b rdata=%h, want 1 01000005", a_m1_ack, a_m1_rdata);
            miscompares++;
        end
        m1_req = 1'b0;
        tick();
    endtask

    initial begin
        b_mem_rdata = 32'h0;
        test_reset();
        test_single_read();
        test_byte_write();
        test_back_to_back();
        test_latency3();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_mem_port_arbiter
